// File: rtl/mult32x32_arbiter.sv
// Round-robin arbiter sharing one iterative 32x32 multiplier between NUM_REQ requesters.
// Optional performance counters are enabled by defining MULT32X32_ARB_PERF_CNT_EN.
module mult32x32_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [63:0]            rsp_product,
    output logic                   mul_start,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic                   mul_busy,
    input  logic [63:0]            mul_product
`ifdef MULT32X32_ARB_PERF_CNT_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [ID_W:0] NUM_REQ_X = (ID_W+1)'(NUM_REQ);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     gnt_id_r;
    logic [NUM_REQ-1:0]  rot_s;
    logic [ID_W-1:0]     gnt_idx_s;
    logic [ID_W-1:0]     gnt_nxt_s;
    logic                grant_s;
    logic [31:0]         sel_a_s;
    logic [31:0]         sel_b_s;

    // Modular add on requester indices; both operands are below NUM_REQ.
    function automatic logic [ID_W-1:0] ptr_add(input logic [ID_W-1:0] base,
                                                input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_REQ_X) begin
            sum = sum - NUM_REQ_X;
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    function automatic logic [ID_W-1:0] first_set(input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] pos;
        pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = v[k] ? ID_W'(k) : pos;
        end
        return pos;
    endfunction

    // Cyclic search for the first valid requester at or after rr_ptr.
    always_comb begin
        rot_s     = NUM_REQ'({req_valid, req_valid} >> rr_ptr_r);
        gnt_idx_s = ptr_add(rr_ptr_r, first_set(rot_s));
        gnt_nxt_s = ptr_add(gnt_idx_s, ID_W'(1));
        grant_s   = (state_r == ST_IDLE) && (|req_valid) && !reset;
    end

    // Operand mux for the requester being granted this cycle.
    always_comb begin
        sel_a_s = 32'd0;
        sel_b_s = 32'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_a_s = (gnt_idx_s == ID_W'(k)) ? req_a[32*k +: 32] : sel_a_s;
            sel_b_s = (gnt_idx_s == ID_W'(k)) ? req_b[32*k +: 32] : sel_b_s;
        end
    end

    // Accept strobe: one-hot to the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (grant_s) begin
            req_ready = NUM_REQ'(1) << gnt_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_nxt_s = ST_LAUNCH;
                else         state_nxt_s = ST_IDLE;
            end
            ST_LAUNCH: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (!mul_busy) state_nxt_s = ST_RESP;
                else           state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and start pulse (high exactly while in LAUNCH).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            mul_start <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mul_start <= (state_nxt_s == ST_LAUNCH);
        end
    end

    // Grant capture: operands stay frozen on the multiplier until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a    <= 32'd0;
            mul_b    <= 32'd0;
            gnt_id_r <= '0;
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            mul_a    <= sel_a_s;
            mul_b    <= sel_b_s;
            gnt_id_r <= gnt_idx_s;
            rr_ptr_r <= gnt_nxt_s;
        end else begin
            mul_a    <= mul_a;
            mul_b    <= mul_b;
            gnt_id_r <= gnt_id_r;
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Response register: product taken the first WAIT cycle busy reads low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= 64'd0;
        end else if ((state_r == ST_WAIT) && !mul_busy) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= gnt_id_r;
            rsp_product <= mul_product;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid   <= 1'b0;
        end else begin
            rsp_valid   <= rsp_valid;
        end
    end

`ifdef MULT32X32_ARB_PERF_CNT_EN
    // Completed-response and requester-stall counters, free-running with wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops         <= 32'd0;
            perf_wait_cycles <= 32'd0;
        end else begin
            if (rsp_valid && rsp_ready) perf_ops <= perf_ops + 32'd1;
            else                        perf_ops <= perf_ops;
            if (|(req_valid & ~req_ready)) perf_wait_cycles <= perf_wait_cycles + 32'd1;
            else                           perf_wait_cycles <= perf_wait_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Self-checking bench for mult32x32_arbiter with a behavioural multiplier and transaction-level model.
module tb_mult32x32_arbiter;
    localparam int NR = 2;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [32*NR-1:0]  req_a;
    logic [32*NR-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [63:0]       rsp_product;
    logic              mul_start;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic              mul_busy;
    logic [63:0]       mul_product;
`ifdef MULT32X32_ARB_PERF_CNT_EN
    logic [31:0]       perf_ops;
    logic [31:0]       perf_wait_cycles;
`endif

    int          errors = 0;
    int          checks = 0;
    int          rr_m = 0;
    int          exp_ops = 0;
    int          exp_wait = 0;
    int          busy_len = 4;
    int          busy_cnt;
    logic [31:0] op_a [NR];
    logic [31:0] op_b [NR];

    always #5 clk = ~clk;

    mult32x32_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_product(mul_product)
`ifdef MULT32X32_ARB_PERF_CNT_EN
        , .perf_ops(perf_ops), .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    // Behavioural iterative multiplier: busy for busy_len cycles after start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_busy    <= 1'b0;
            mul_product <= 64'd0;
            busy_cnt    <= 0;
        end else if (mul_start) begin
            if (busy_len == 0) begin
                mul_product <= 64'(mul_a) * 64'(mul_b);
            end else begin
                mul_busy    <= 1'b1;
                busy_cnt    <= busy_len - 1;
                mul_product <= 64'h0BAD_0BAD_0BAD_0BAD;
            end
        end else if (mul_busy) begin
            if (busy_cnt == 0) begin
                mul_busy    <= 1'b0;
                mul_product <= 64'(mul_a) * 64'(mul_b);
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < NR; k++) begin
            req_a[32*k +: 32] = op_a[k];
            req_b[32*k +: 32] = op_b[k];
        end
    endtask

    function automatic int pick(input logic [NR-1:0] m, input int rr);
        for (int k = 0; k < NR; k++) begin
            if (((int'(m) >> ((rr + k) % NR)) & 1) == 1) return (rr + k) % NR;
        end
        return 0;
    endfunction

    task automatic check_perf();
`ifdef MULT32X32_ARB_PERF_CNT_EN
        chk("perf_ops", 64'(perf_ops), 64'(exp_ops));
        chk("perf_wait_cycles", 64'(perf_wait_cycles), 64'(exp_wait));
`endif
    endtask

    // One complete transaction: grant, launch, wait, response with dly cycles of backpressure.
    task automatic do_op(input logic [NR-1:0] mask, input int nbusy, input int dly);
        int          g;
        int          n;
        logic [31:0] a_g;
        logic [31:0] b_g;
        logic [63:0] prod;
        logic [NR-1:0] rest;
        g    = pick(mask, rr_m);
        a_g  = op_a[g];
        b_g  = op_b[g];
        prod = 64'(a_g) * 64'(b_g);
        busy_len  = nbusy;
        rsp_ready = 1'b0;
        req_valid = mask;
        pack();
        #1;
        chk("grant_onehot", 64'(req_ready), 64'(1) << g);
        rest = mask & ~NR'(64'(1) << g);
        if (rest != '0) exp_wait++;
        tick();
        req_valid = rest;
        chk("start_pulse", 64'(mul_start), 64'd1);
        chk("mul_a_grant", 64'(mul_a), 64'(a_g));
        chk("mul_b_grant", 64'(mul_b), 64'(b_g));
        chk("ready_low_launch", 64'(req_ready), 64'd0);
        n = 0;
        do begin
            op_a[g] = $urandom;
            op_b[g] = $urandom;
            pack();
            if (rest != '0) exp_wait++;
            tick();
            n++;
            chk("start_once", 64'(mul_start), 64'd0);
            chk("mul_a_hold", 64'(mul_a), 64'(a_g));
            chk("mul_b_hold", 64'(mul_b), 64'(b_g));
            chk("ready_low_busy", 64'(req_ready), 64'd0);
        end while (rsp_valid !== 1'b1 && n < 64);
        chk("latency", 64'(n), 64'(2 + nbusy));
        chk("rsp_product", rsp_product, prod);
        chk("rsp_id", 64'(rsp_id), 64'(g));
        for (int d = 0; d < dly; d++) begin
            if (rest != '0) exp_wait++;
            tick();
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_product", rsp_product, prod);
            chk("bp_id", 64'(rsp_id), 64'(g));
            chk("bp_no_grant", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("no_grant_handshake", 64'(req_ready), 64'd0);
        if (rest != '0) exp_wait++;
        tick();
        rsp_ready = 1'b0;
        exp_ops++;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        rr_m = (g + 1) % NR;
        check_perf();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_product", rsp_product, 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        reset     = 1'b0;
        req_valid = '0;
        tick();
        check_perf();

        op_a[0] = 32'h0000_0003; op_b[0] = 32'h0000_0005;
        op_a[1] = 32'h0000_0000; op_b[1] = 32'h0000_0000;
        do_op(2'b01, 4, 0);

        op_a[1] = 32'h0001_0000; op_b[1] = 32'h0001_0000;
        do_op(2'b10, 0, 0);

        for (int i = 0; i < 4; i++) begin
            op_a[0] = $urandom; op_b[0] = $urandom;
            op_a[1] = $urandom; op_b[1] = $urandom;
            do_op(2'b11, 2, 1);
        end

        op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'hFFFF_FFFF;
        op_a[1] = $urandom;      op_b[1] = $urandom;
        do_op(2'b11, 3, 10);

        op_a[0] = $urandom; op_b[0] = $urandom;
        busy_len  = 4;
        req_valid = 2'b11;
        pack();
        tick();
        req_valid = 2'b00;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_mul_start", 64'(mul_start), 64'd0);
        chk("midrst_mul_a", 64'(mul_a), 64'd0);
        chk("midrst_rsp_product", rsp_product, 64'd0);
        tick();
        reset    = 1'b0;
        rr_m     = 0;
        exp_ops  = 0;
        exp_wait = 0;
        check_perf();
        op_a[0] = $urandom; op_b[0] = $urandom;
        op_a[1] = $urandom; op_b[1] = $urandom;
        do_op(2'b11, 3, 0);

        for (int i = 0; i < 12; i++) begin
            op_a[0] = $urandom; op_b[0] = $urandom;
            op_a[1] = $urandom; op_b[1] = $urandom;
            do_op(NR'($urandom_range(1, 3)), $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
